stage1_if: RTL and testbench

Instruction-fetch stage; sits directly upstream of the decode stage and feeds it through the IF/ID pipeline register.
- Owns the program counter.
- Issues one-outstanding-request fetches to instruction memory.
- Absorbs a response that arrives while decode is stalled in a one-entry skid buffer.
- Applies branch/jump redirects from later stages.
- Produces the registered instruction, PC+4 and the flush pulse that decode consumes.

---
 rtl/stage1_if.sv | 154 +++++++++++++++
 tb/tb_stage1_if.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/stage1_if.sv
// rtl/stage1_if.sv - instruction-fetch stage with one-entry response skid buffer
//
// Purpose:
//   Owns the program counter and issues fetches to instruction memory, with
//   one request outstanding at a time. It applies redirects from later
//   stages. A response that arrives while decode is stalled is parked in a
//   one-entry skid buffer. The stage drives the IF/ID register (instruction,
//   PC+4) and a one-cycle flush pulse.
//
// Ports:
//   clk, rstb          clock (rising edge), asynchronous active-low reset
//   hold               hazard stall; freezes the IF/ID register
//   pc_src             redirect request, valid this cycle
//   branch_target      redirect PC
//   imem_req           fetch request (accepted on every rising edge it is high)
//   imem_addr          fetch address, always the current pc
//   imem_valid         fetch response valid
//   imem_rdata         fetch response instruction
//   instr_out          IF/ID instruction (0 = bubble)
//   pc_plus4_out       IF/ID PC+4
//   if_flush           squash pulse to decode, one cycle per redirect cycle
module stage1_if #(
  parameter int unsigned               DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]     RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  hold,
  input  logic                  pc_src,
  input  logic [DATA_WIDTH-1:0] branch_target,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_valid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [DATA_WIDTH-1:0] pc_plus4_out,
  output logic                  if_flush
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // request on the bus this cycle
    S_WAIT = 2'd1,  // waiting for the response to the issued request
    S_FULL = 2'd2,  // response parked in skid, waiting for hold to drop
    S_DROP = 2'd3   // outstanding response belongs to a squashed fetch
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc4_q, pc4_d;
  logic                  flush_q, flush_d;

  logic [DATA_WIDTH-1:0] pc_inc;
  logic                  deliver;
  logic [DATA_WIDTH-1:0] deliver_data;

  // Wraps modulo 2^DATA_WIDTH by construction.
  assign pc_inc = pc_q + DATA_WIDTH'(4);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_d       = skid_q;
    deliver      = 1'b0;
    deliver_data = skid_q;

    case (state_q)
      S_REQ: begin
        // The request goes out on this edge whatever happens, so a redirect
        // here still leaves one response in flight that must be dropped.
        if (pc_src) begin
          pc_d    = branch_target;
          state_d = S_DROP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (pc_src) begin
          pc_d    = branch_target;
          state_d = imem_valid ? S_REQ : S_DROP;
        end else if (imem_valid && !hold) begin
          deliver      = 1'b1;
          deliver_data = imem_rdata;
          pc_d         = pc_inc;
          state_d      = S_REQ;
        end else if (imem_valid) begin
          skid_d  = imem_rdata;
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (pc_src) begin
          pc_d    = branch_target;
          state_d = S_REQ;
        end else if (!hold) begin
          deliver      = 1'b1;
          deliver_data = skid_q;
          pc_d         = pc_inc;
          state_d      = S_REQ;
        end
      end
      S_DROP: begin
        if (pc_src) begin
          pc_d = branch_target;
        end else if (imem_valid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // IF/ID register: a redirect always squashes, a delivery loads, a stall
    // holds, and otherwise a bubble is inserted (pc_plus4 keeps its value).
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (pc_src) begin
      instr_d = '0;
    end else if (deliver) begin
      instr_d = deliver_data;
      pc4_d   = pc_inc;
    end else if (!hold) begin
      instr_d = '0;
    end

    flush_d = pc_src;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      skid_q  <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      flush_q <= flush_d;
    end
  end

  assign imem_req     = (state_q == S_REQ);
  assign imem_addr    = pc_q;
  assign instr_out    = instr_q;
  assign pc_plus4_out = pc4_q;
  assign if_flush     = flush_q;

endmodule

// File: tb/tb_stage1_if.sv
// tb/tb_stage1_if.sv - self-checking bench for stage1_if with a delivery scoreboard
module tb_stage1_if;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, RESET_PC = 0
  logic        rstb, hold, pc_src, imem_valid;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, if_flush;
  logic [31:0] imem_addr, instr_out, pc_plus4_out;

  // Wrap instance, RESET_PC = 32'hFFFFFFFC
  logic        w_rstb, w_hold, w_pc_src, w_valid;
  logic [31:0] w_target, w_rdata;
  logic        w_req, w_flush;
  logic [31:0] w_addr, w_instr, w_pc4;

  stage1_if #(.DATA_WIDTH(32), .RESET_PC(32'h00000000)) u_dut (
    .clk(clk), .rstb(rstb), .hold(hold), .pc_src(pc_src),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .instr_out(instr_out),
    .pc_plus4_out(pc_plus4_out), .if_flush(if_flush)
  );

  stage1_if #(.DATA_WIDTH(32), .RESET_PC(32'hFFFFFFFC)) u_wrap (
    .clk(clk), .rstb(w_rstb), .hold(w_hold), .pc_src(w_pc_src),
    .branch_target(w_target), .imem_req(w_req), .imem_addr(w_addr),
    .imem_valid(w_valid), .imem_rdata(w_rdata), .instr_out(w_instr),
    .pc_plus4_out(w_pc4), .if_flush(w_flush)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_pc;
  logic [31:0] prev_instr = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Every new non-bubble instruction on the IF/ID register must match the
  // oldest expected delivery.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rstb && instr_out != 32'h0 && instr_out != prev_instr) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", instr_out, 32'h0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_instr", instr_out, e[63:32]);
        chk("sb_pc4", pc_plus4_out, e[31:0]);
      end
    end
    prev_instr = instr_out;
  end

  // Starts at a negedge in S_REQ, ends at the negedge after the delivery edge.
  task automatic fetch_one(input logic [31:0] data);
    chk("fetch_req", {31'b0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    @(negedge clk);
    chk("wait_noreq", {31'b0, imem_req}, 32'd0);
    chk("bubble", instr_out, 32'h0);
    imem_valid = 1'b1;
    imem_rdata = data;
    exp_pc     = exp_pc + 32'd4;
    sb_q.push_back({data, exp_pc});
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
  endtask

  initial begin
    rstb = 1'b0; hold = 1'b0; pc_src = 1'b0; branch_target = 32'h0;
    imem_valid = 1'b0; imem_rdata = 32'h0;
    w_rstb = 1'b0; w_hold = 1'b0; w_pc_src = 1'b0; w_target = 32'h0;
    w_valid = 1'b0; w_rdata = 32'h0;
    exp_pc = 32'h0;

    // Reset
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    chk("rst_req", {31'b0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_pc4", pc_plus4_out, 32'h0);
    chk("rst_flush", {31'b0, if_flush}, 32'd0);

    // Streaming, one-cycle memory latency
    fetch_one(32'h20080001);
    fetch_one(32'h20090002);
    fetch_one(32'h200A0003);

    // Skid buffer: hold rises with the response and stays up three edges
    chk("skid_req", {31'b0, imem_req}, 32'd1);
    chk("skid_addr", imem_addr, 32'd12);
    @(negedge clk);
    hold = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h8C0B0004;
    sb_q.push_back({32'h8C0B0004, 32'd16});
    @(negedge clk);
    imem_valid = 1'b0; imem_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      chk("skid_noreq", {31'b0, imem_req}, 32'd0);
      chk("skid_frozen", instr_out, 32'h0);
      @(negedge clk);
    end
    chk("skid_noreq", {31'b0, imem_req}, 32'd0);
    hold = 1'b0;
    @(negedge clk);
    chk("skid_out", instr_out, 32'h8C0B0004);
    chk("skid_next_req", {31'b0, imem_req}, 32'd1);
    chk("skid_next_addr", imem_addr, 32'd16);

    // Redirect in S_WAIT without a response; response lands two edges later
    @(negedge clk);
    pc_src = 1'b1; branch_target = 32'h100;
    @(negedge clk);
    pc_src = 1'b0;
    chk("rdw_flush", {31'b0, if_flush}, 32'd1);
    chk("rdw_instr", instr_out, 32'h0);
    chk("rdw_noreq", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    chk("rdw_flush_end", {31'b0, if_flush}, 32'd0);
    chk("rdw_drop_noreq", {31'b0, imem_req}, 32'd0);
    imem_valid = 1'b1; imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    imem_valid = 1'b0; imem_rdata = 32'h0;
    chk("rdw_discard", instr_out, 32'h0);
    chk("rdw_req", {31'b0, imem_req}, 32'd1);
    chk("rdw_addr", imem_addr, 32'h100);

    // Redirect coincident with the response
    @(negedge clk);
    pc_src = 1'b1; branch_target = 32'h40; imem_valid = 1'b1; imem_rdata = 32'hBADC0DE0;
    @(negedge clk);
    pc_src = 1'b0; imem_valid = 1'b0; imem_rdata = 32'h0;
    chk("rdv_req", {31'b0, imem_req}, 32'd1);
    chk("rdv_addr", imem_addr, 32'h40);
    chk("rdv_flush", {31'b0, if_flush}, 32'd1);
    chk("rdv_instr", instr_out, 32'h0);
    exp_pc = 32'h40;
    fetch_one(32'h11110005);
    chk("rdv_flush_end", {31'b0, if_flush}, 32'd0);

    // PC wrap and asynchronous reset mid-WAIT on the second instance
    chk("wrap_rst_addr", w_addr, 32'hFFFFFFFC);
    w_rstb = 1'b1;
    chk("wrap_req", {31'b0, w_req}, 32'd1);
    @(negedge clk);
    w_valid = 1'b1; w_rdata = 32'h0BADF00D;
    @(negedge clk);
    w_valid = 1'b0; w_rdata = 32'h0;
    chk("wrap_instr", w_instr, 32'h0BADF00D);
    chk("wrap_pc4", w_pc4, 32'h0);
    chk("wrap_addr", w_addr, 32'h0);
    chk("wrap_req2", {31'b0, w_req}, 32'd1);
    w_hold = 1'b1;
    @(negedge clk);
    chk("wrap_wait_noreq", {31'b0, w_req}, 32'd0);
    chk("wrap_held", w_instr, 32'h0BADF00D);
    #2 w_rstb = 1'b0;
    #1;
    chk("arst_instr", w_instr, 32'h0);
    chk("arst_pc4", w_pc4, 32'h0);
    chk("arst_flush", {31'b0, w_flush}, 32'd0);
    chk("arst_addr", w_addr, 32'hFFFFFFFC);
    chk("arst_req", {31'b0, w_req}, 32'd1);

    @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
